// File: rtl/pipe_stage_chain.sv
// Elastic register chain of DEPTH stages with valid/ready handshakes, flush,
// occupancy report and saturating stall/flush performance counters.
module pipe_stage_chain #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  input  logic                       cnt_clr,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  r_v;
  logic [DATA_W-1:0] r_d [DEPTH];
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic [DEPTH:0]    w_rdy;
  logic              w_chain;
  logic [DEPTH-1:0]  w_vin;
  logic [DATA_W-1:0] w_din [DEPTH];
  logic [OCC_W-1:0]  w_occ;
  logic              w_stall;
  logic              w_flush_hit;

  // Ready ripples back from the consumer: a stage is ready if it or any later stage has a hole.
  always_comb begin
    w_chain      = out_ready;
    w_rdy        = '0;
    w_rdy[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_chain  = w_chain | ~r_v[k];
      w_rdy[k] = w_chain;
    end
  end

  // Incoming valid/data for each stage: the chain input for stage 0, the previous stage otherwise.
  always_comb begin
    w_vin    = '0;
    w_vin[0] = in_valid;
    w_din[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      w_vin[k] = r_v[k-1];
      w_din[k] = r_d[k-1];
    end
  end

  // Occupancy is the popcount of stage valids.
  always_comb begin
    w_occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_occ = w_occ + OCC_W'(r_v[k]);
    end
  end

  assign w_stall     = r_v[DEPTH-1] & ~out_ready;
  assign w_flush_hit = flush & (w_occ != '0);

  // Stage registers: reset clears everything, flush drops valids only, otherwise ready stages advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_d[k] <= '0;
      end
    end else if (flush) begin
      r_v <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_rdy[k]) begin
          r_v[k] <= w_vin[k];
          if (w_vin[k]) begin
            r_d[k] <= w_din[k];
          end
        end
      end
    end
  end

  // Saturating performance counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_hit && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready  = w_rdy[0] & ~flush & ~rst;
  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];
  assign occupancy = w_occ;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench: DEPTH=3 chain for all behaviours, DEPTH=1 and DEPTH=8 chains
// sharing the same inputs for the streaming latency/throughput sweep.
module tb_pipe_stage_chain;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, cnt_clr;
  logic [31:0] in_data;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [1:0]  a_occ;
  logic [3:0]  a_stall, a_flush;

  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [0:0]  b_occ;
  logic [3:0]  b_stall, b_flush;

  logic        c_in_ready, c_out_valid;
  logic [31:0] c_out_data;
  logic [3:0]  c_occ;
  logic [3:0]  c_stall, c_flush;

  int checks = 0;
  int errors = 0;
  logic [31:0] vals [4];

  always #5 clk = ~clk;

  pipe_stage_chain #(.DATA_W(32), .DEPTH(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .cnt_clr(cnt_clr), .stall_cnt(a_stall), .flush_cnt(a_flush));

  pipe_stage_chain #(.DATA_W(32), .DEPTH(1), .CNT_W(4)) dut_d1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .cnt_clr(cnt_clr), .stall_cnt(b_stall), .flush_cnt(b_flush));

  pipe_stage_chain #(.DATA_W(32), .DEPTH(8), .CNT_W(4)) dut_d8 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
    .occupancy(c_occ), .cnt_clr(cnt_clr), .stall_cnt(c_stall), .flush_cnt(c_flush));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // After the edge ending cycle cyc, a chain of latency lat presents entry cyc+1-lat.
  task automatic chk_stream(input string tag, input int lat, input int cyc,
                            input logic ov, input logic [31:0] od);
    int idx;
    idx = cyc + 1 - lat;
    chk({tag, "_valid"}, 64'(ov), 64'((idx >= 0) && (idx < 4)));
    if ((idx >= 0) && (idx < 4)) begin
      chk({tag, "_data"}, 64'(od), 64'(vals[idx]));
    end
  endtask

  initial begin
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    in_data = 32'h0;
    tick();
    tick();
    chk("rst_in_ready", 64'(a_in_ready), 64'd0);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_data", 64'(a_out_data), 64'd0);
    chk("rst_occ", 64'(a_occ), 64'd0);
    chk("rst_stall", 64'(a_stall), 64'd0);
    chk("rst_flush", 64'(a_flush), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(a_out_valid), 64'd0);

    // Streaming on all three depths at once
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid = (cyc < 4);
      in_data  = vals[cyc % 4];
      #1;
      chk("d3_in_ready", 64'(a_in_ready), 64'd1);
      chk("d1_in_ready", 64'(b_in_ready), 64'd1);
      chk("d8_in_ready", 64'(c_in_ready), 64'd1);
      tick();
      chk_stream("d3", 3, cyc, a_out_valid, a_out_data);
      chk_stream("d1", 1, cyc, b_out_valid, b_out_data);
      chk_stream("d8", 8, cyc, c_out_valid, c_out_data);
    end
    in_valid = 1'b0;
    chk("stream_occ_empty", 64'(a_occ), 64'd0);
    chk("stream_no_stall", 64'(a_stall), 64'd0);

    // Backpressure: 5 offered, 3 accepted
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1;
      in_data  = 32'hA1 + 32'(j);
      #1;
      chk("bp_in_ready", 64'(a_in_ready), 64'(j < 3));
      tick();
      chk("bp_stall", 64'(a_stall), 64'((j > 2) ? (j - 2) : 0));
    end
    chk("bp_occ", 64'(a_occ), 64'd3);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("drain_valid", 64'(a_out_valid), 64'd1);
      chk("drain_data", 64'(a_out_data), 64'(32'hA1 + 32'(k)));
      tick();
    end
    chk("drain_done_valid", 64'(a_out_valid), 64'd0);
    chk("drain_done_occ", 64'(a_occ), 64'd0);
    chk("drain_stall_hold", 64'(a_stall), 64'd2);

    // Flush with two entries in flight and a competing input
    in_valid = 1'b1; in_data = 32'hB1;
    tick();
    in_data = 32'hB2;
    tick();
    chk("pre_flush_occ", 64'(a_occ), 64'd2);
    flush = 1'b1; in_data = 32'hB3;
    #1;
    chk("flush_in_ready", 64'(a_in_ready), 64'd0);
    tick();
    chk("flush_occ", 64'(a_occ), 64'd0);
    chk("flush_out_valid", 64'(a_out_valid), 64'd0);
    chk("flush_cnt_one", 64'(a_flush), 64'd1);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("flush_input_dropped", 64'(a_occ), 64'd0);
    flush = 1'b1;
    tick();
    chk("flush_empty_cnt", 64'(a_flush), 64'd1);
    flush = 1'b0;

    // Counter saturation and clear
    cnt_clr = 1'b1;
    tick();
    chk("clr_stall", 64'(a_stall), 64'd0);
    chk("clr_flush", 64'(a_flush), 64'd0);
    cnt_clr = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hC1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 22; k++) begin
      tick();
    end
    chk("stall_saturate", 64'(a_stall), 64'd15);
    chk("stall_data_held", 64'(a_out_data), 64'hC1);
    cnt_clr = 1'b1;
    tick();
    chk("stall_clr_priority", 64'(a_stall), 64'd0);
    cnt_clr = 1'b0;
    tick();
    chk("stall_resume", 64'(a_stall), 64'd1);

    // Reset in the middle of a stalled, full chain
    in_valid = 1'b1; in_data = 32'hD1;
    tick();
    in_data = 32'hD2;
    tick();
    chk("mid_occ_full", 64'(a_occ), 64'd3);
    rst = 1'b1; flush = 1'b1; cnt_clr = 1'b0;
    tick();
    chk("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("mid_rst_out_data", 64'(a_out_data), 64'd0);
    chk("mid_rst_occ", 64'(a_occ), 64'd0);
    chk("mid_rst_stall", 64'(a_stall), 64'd0);
    chk("mid_rst_flush", 64'(a_flush), 64'd0);
    chk("mid_rst_in_ready", 64'(a_in_ready), 64'd0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("mid_release_in_ready", 64'(a_in_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the payload width in bits; legal values are 1 or more.
REQ-002 The block SHALL have parameter DEPTH, default 1, meaning the number of register stages; legal values are 1 to 8.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of the performance counters.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-007 Port flush, input, 1 bit, SHALL discard all in-flight entries.
REQ-008 Port in_valid, input, 1 bit, SHALL mean that in_data holds a valid payload.
REQ-009 Port in_ready, output, 1 bit, SHALL mean that the chain accepts in_data this cycle.
REQ-010 Port in_data, input, DATA_W bits, SHALL carry the payload from the upstream stage.
REQ-011 Port out_valid, output, 1 bit, SHALL mean that the last stage holds a valid entry.
REQ-012 Port out_ready, input, 1 bit, SHALL mean that the downstream consumer accepts an entry.
REQ-013 Port out_data, output, DATA_W bits, SHALL carry the payload of the last stage.
REQ-014 Port occupancy, output, clog2(DEPTH+1) bits, SHALL give the count of valid stages.
REQ-015 Port cnt_clr, input, 1 bit, SHALL clear both performance counters.
REQ-016 Port stall_cnt, output, CNT_W bits, SHALL count backpressure cycles.
REQ-017 Port flush_cnt, output, CNT_W bits, SHALL count effective flushes.

Function
REQ-018 The chain SHALL hold per-stage registers v[k] and d[k] for k = 0..DEPTH-1; stage 0 receives input, and stage DEPTH-1 drives out_valid/out_data.
REQ-019 The per-stage ready rdy[k] SHALL equal !v[k] || rdy[k+1], with rdy[DEPTH] = out_ready; this path is combinational, giving full throughput with no bubbles.
REQ-020 in_ready SHALL equal rdy[0] && !flush && !rst.
REQ-021 On each edge, when not flushing, every stage with rdy[k]=1 SHALL load v[k] from the previous stage's valid (in_valid for k=0); it SHALL load d[k] only when that incoming valid is 1, otherwise d[k] holds.
REQ-022 A stage with rdy[k]=0 SHALL hold both v[k] and d[k].
REQ-023 Latency SHALL be exactly DEPTH cycles from an accepted input to out_valid=1 when out_ready stays 1; sustained throughput SHALL be 1 entry per cycle.
REQ-024 Order SHALL be preserved; no entry is duplicated or dropped, except by flush.
REQ-025 When flush=1, all v[k] SHALL be set to 0 at the edge; d[k] is unchanged; in_valid is not accepted.
REQ-026 If out_valid && out_ready && flush in the same cycle, the output transfer SHALL count as completed, and all other entries are discarded.
REQ-027 occupancy SHALL be the combinational popcount of v[].
REQ-028 stall_cnt SHALL increment by 1 on each cycle with out_valid=1 && out_ready=0, and SHALL saturate at 2^CNT_W-1.
REQ-029 flush_cnt SHALL increment by 1 on each cycle with flush=1 && occupancy!=0, and SHALL saturate at all-ones.
REQ-030 cnt_clr=1 SHALL zero both counters at the edge, taking priority over an increment in the same cycle.
REQ-031 out_data SHALL equal d[DEPTH-1] at all times; it is stable but meaningless when out_valid=0.

Reset
REQ-032 While rst=1, at the edge all v[k] SHALL become 0, all d[k] 0, and stall_cnt and flush_cnt 0; in_ready SHALL read 0.
REQ-033 rst SHALL take priority over flush, cnt_clr and all handshakes, including reset asserted mid-stream.
REQ-034 In the first cycle after rst deasserts, out_valid SHALL be 0, occupancy 0, and in_ready 1.

Verification (DEPTH=3, DATA_W=32, CNT_W=4)
REQ-035 Streaming: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with out_ready=1 -> out_valid rises 3 cycles after the first accept, out_data shows 0x11..0x44 on consecutive cycles, and in_ready stays 1.
REQ-036 Backpressure: hold out_ready=0, push 5 entries -> 3 are accepted, in_ready=0 from the 4th cycle, occupancy=3, stall_cnt increments each stalled cycle; release out_ready -> data drains in order with no loss.
REQ-037 Flush: occupancy=2, flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, the input is not accepted, and flush_cnt=1; flush with occupancy=0 leaves flush_cnt unchanged.
REQ-038 Saturation and clear: stall for 20 cycles -> stall_cnt=15; cnt_clr=1 while stalled -> next cycle stall_cnt=0.
REQ-039 Reset mid-operation: rst=1 with occupancy=3 and counters nonzero -> next cycle all outputs are 0 and in_ready=1 after release.
REQ-040 Parameter sweep: the stream test SHALL be repeated for DEPTH=1 and DEPTH=8 -> latency equals DEPTH and full throughput is kept.
